mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
- REQ-001 Parameter: MEM_BYTES, default 1024, data memory size in bytes; byte-addressed, little-endian.
- REQ-002 Clock and reset ports: clk input 1 is the single clock (all state on posedge); rst input 1 is the reset, synchronous and active-high.
- REQ-003 Pipeline inputs, driven by the M pipeline register:
  - M_stat input 3: stage status.
  - M_icode input 4: instruction code.
  - M_Cnd input 1: condition flag; passed through unused.
  - M_valE input 64: ALU result / address.
  - M_valA input 64: store data / stack address.
  - M_dstE, M_dstM input 4 each: destination registers.
- REQ-004 Control inputs: W_stall input 1 holds the W register; W_bubble input 1 loads a NOP into the W register.
- REQ-005 Combinational outputs, used for forwarding and hazard control: m_stat output 3 (memory-stage status); m_valM output 64 (memory read data).
- REQ-006 Registered outputs: W_stat output 3, W_icode output 4, W_valE output 64, W_valM output 64, W_dstE output 4, W_dstM output 4.

Function
- REQ-007 Encodings:
  - Status: AOK=1, HLT=2, ADR=3, INS=4.
  - icode: RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B, NOP=1.
  - RNONE=F.
- REQ-008 Read when M_icode is MRMOVQ, POPQ or RET; write when M_icode is RMMOVQ, PUSHQ or CALL; no access for any other icode.
- REQ-009 Access address:
  - M_valA for POPQ and RET.
  - M_valE for RMMOVQ, PUSHQ, CALL and MRMOVQ.
- REQ-010 Address error: an access with unsigned 64-bit address > MEM_BYTES-8; no wrap-around; the address comparison covers all 64 bits.
- REQ-011 Read: combinational, zero latency, 8 bytes at addr..addr+7 little-endian; m_valM = 0 when no read or on address error.
- REQ-012 Write:
  - Data M_valA, 8 bytes little-endian, committed at posedge clk.
  - Only when the access is a write, there is no address error, M_stat==AOK and rst==0.
- REQ-013 Same-cycle read and write to overlapping bytes: impossible for a single instruction; a read in cycle N returns contents committed at or before the cycle-N edge.
- REQ-014 m_stat = ADR on address error, else M_stat.
- REQ-015 W register update at posedge clk, in priority order:
  - rst.
  - Else W_stall: hold all W_* outputs.
  - Else W_bubble: W_icode=NOP, W_stat=AOK, W_dstE=W_dstM=RNONE, W_valE=W_valM=0.
  - Else load: W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM, W_dstE<=M_dstE, W_dstM<=M_dstM.
- REQ-016 W_stall and W_bubble both high: stall wins; bubble is ignored.
- REQ-017 Memory writes are independent of W_stall and W_bubble (REQ-012 alone governs them).
- REQ-018 Store-to-load: a load in cycle N+1 from the address stored in cycle N returns the new data.

Reset
- REQ-019 While rst is sampled high at posedge clk:
  - W_stat=AOK, W_icode=NOP, W_valE=0, W_valM=0, W_dstE=RNONE, W_dstM=RNONE.
  - All memory bytes are cleared to 0.
- REQ-020 rst overrides W_stall, W_bubble and any pending write, including a reset asserted mid-sequence.
- REQ-021 First edge after rst deasserts: normal operation per REQ-015.

Verification
- REQ-022 Store then load:
  - Cycle 1: RMMOVQ, valE=0x10, valA=0x1122334455667788.
  - Cycle 2: MRMOVQ, valE=0x10.
  - Required: m_valM=0x1122334455667788; next edge W_valM equals it and W_stat=AOK.
- REQ-023 Byte order: after the REQ-022 store, MRMOVQ valE=0x11 -> m_valM=0x0011223344556677.
- REQ-024 Address boundary (MEM_BYTES=1024):
  - MRMOVQ valE=1016 -> m_stat=AOK.
  - valE=1017 -> m_stat=ADR, m_valM=0.
  - PUSHQ valE=0xFFFFFFFFFFFFFFF8 -> ADR and no memory change.
- REQ-025 Stall and bubble:
  - W loaded with OPQ, dstE=3, valE=5; then W_stall=1 with new inputs -> W unchanged.
  - W_stall=W_bubble=1 -> unchanged.
  - W_bubble=1 alone -> W_icode=1, W_dstE=F.
- REQ-026 Write suppression: RMMOVQ with M_stat=HLT, valE=0x20, valA=7 -> a later load from 0x20 returns 0.
- REQ-027 Reset mid-operation:
  - rst=1 in the same cycle as a valid RMMOVQ to 0x40 -> W cleared per REQ-019.
  - Load from 0x40 after reset returns 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory access stage and W pipeline register.
// Holds the byte-addressed data memory and feeds forwarding paths.
module mem_wb_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [2:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    logic [7:0]    mem [MEM_BYTES];
    logic          is_rd;
    logic          is_wr;
    logic          use_a;
    logic [63:0]   addr;
    logic          adr_err;
    logic          wr_en;
    logic [AW-1:0] base;
    logic          unused_cnd;

    assign unused_cnd = M_Cnd;

    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        use_a = 1'b0;
        unique case (1'b1)
            (M_icode == I_MRMOVQ): is_rd = 1'b1;
            (M_icode == I_POPQ),
            (M_icode == I_RET): begin
                is_rd = 1'b1;
                use_a = 1'b1;
            end
            (M_icode == I_RMMOVQ),
            (M_icode == I_PUSHQ),
            (M_icode == I_CALL): is_wr = 1'b1;
            default: ;
        endcase
    end

    // Full 64-bit compare so huge addresses never alias into memory.
    assign addr    = use_a ? M_valA : M_valE;
    assign adr_err = (is_rd || is_wr) && (addr > MAX_ADDR);
    assign base    = addr[AW-1:0];
    assign wr_en   = is_wr && !adr_err && (M_stat == S_AOK);
    assign m_stat  = adr_err ? S_ADR : M_stat;

    always_comb begin
        m_valM = '0;
        if (is_rd && !adr_err) begin
            for (int i = 0; i < 8; i++) begin
                m_valM[8*i +: 8] = mem[base + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem[base + AW'(i)] <= M_valA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            W_stat  <= S_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= R_NONE;
            W_dstM  <= R_NONE;
        end else if (W_stall) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
        end else if (W_bubble) begin
            W_stat  <= S_AOK;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= R_NONE;
            W_dstM  <= R_NONE;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
